// File: rtl/y_xd_acc_pkg.sv
// Shared definitions for the y + xD accumulate stage: FP16 width, arithmetic
// latencies, FSM encodings, lane tag payload and the flat element index map.
package y_xd_acc_pkg;

    localparam int unsigned FP16_W  = 16;
    localparam int unsigned ADD_LAT = 11;  // fp16_add_wrapper valid_in -> valid_out
    localparam int unsigned MUL_LAT = 6;   // FP16 multiplier latency used by sibling stages
    localparam int unsigned TAG_IW  = 16;  // element index width carried by lane tags

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Travels alongside each adder so the result knows where it lands.
    typedef struct packed {
        logic              valid;
        logic [TAG_IW-1:0] idx;
    } lane_tag_t;

    // Flat element index e = b*H*P + h*P + p.
    function automatic int unsigned elem_idx(input int unsigned b, input int unsigned h,
                                             input int unsigned p, input int unsigned n_h,
                                             input int unsigned n_p);
        return b * n_h * n_p + h * n_p + p;
    endfunction

endpackage

// File: rtl/fp16_add_wrapper.sv
// Pipelined FP16 adder: round-to-nearest-even, denormals supported, NaN -> 0x7E00.
// Ports: clk; a, b operands; valid_in qualifies a/b; result and valid_out appear LAT cycles later.
// The pipeline has no reset: consumers qualify valid_out with their own reset-cleared state.
module fp16_add_wrapper #(
    parameter int unsigned LAT = 11
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        valid_in,
    output logic [15:0] result,
    output logic        valid_out
);

    logic [15:0] w_x, w_y, w_res;
    logic        s_x, s_y, rnd_up, w_nan;
    logic [5:0]  e_x, e_y, e_r, d;
    logic [10:0] m_x, m_y, m_f;
    logic [13:0] ext_x, ext_y, al_y, m_n;
    logic [14:0] sum;
    logic [11:0] m_rnd;

    logic [15:0] r_res [LAT];
    logic        r_vld [LAT];

    // Combinational add: align, add/subtract, normalise, round, encode.
    always_comb begin
        w_x = a; w_y = b; w_res = '0;
        s_x = 1'b0; s_y = 1'b0; rnd_up = 1'b0; w_nan = 1'b0;
        e_x = '0; e_y = '0; e_r = '0; d = '0;
        m_x = '0; m_y = '0; m_f = '0;
        ext_x = '0; ext_y = '0; al_y = '0; m_n = '0; sum = '0; m_rnd = '0;

        // Larger magnitude goes to x so the subtraction never underflows.
        if (b[14:0] > a[14:0]) begin
            w_x = b;
            w_y = a;
        end
        s_x   = w_x[15];
        s_y   = w_y[15];
        e_x   = (w_x[14:10] == 5'd0) ? 6'd1 : {1'b0, w_x[14:10]};
        e_y   = (w_y[14:10] == 5'd0) ? 6'd1 : {1'b0, w_y[14:10]};
        m_x   = {w_x[14:10] != 5'd0, w_x[9:0]};
        m_y   = {w_y[14:10] != 5'd0, w_y[9:0]};
        ext_x = {m_x, 3'b000};
        ext_y = {m_y, 3'b000};
        d     = e_x - e_y;

        // Align y, folding shifted-out bits into the sticky bit.
        if (d >= 6'd14) al_y = {13'd0, |m_y};
        else            al_y = (ext_y >> d) | {13'd0, |(ext_y & ~(14'h3FFF << d))};

        if (s_x == s_y) begin
            sum = {1'b0, ext_x} + {1'b0, al_y};
            if (sum[14]) begin
                m_n = sum[14:1] | {13'd0, sum[0]};
                e_r = e_x + 6'd1;
            end else begin
                m_n = sum[13:0];
                e_r = e_x;
            end
        end else begin
            m_n = ext_x - al_y;
            e_r = e_x;
            // Normalise left, stopping at the denormal exponent.
            for (int i = 0; i < 14; i++) begin
                if (!m_n[13] && e_r > 6'd1) begin
                    m_n = m_n << 1;
                    e_r = e_r - 6'd1;
                end
            end
        end

        rnd_up = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        m_rnd  = {1'b0, m_n[13:3]} + 12'(rnd_up);
        if (m_rnd[11]) begin
            m_f = m_rnd[11:1];
            e_r = e_r + 6'd1;
        end else begin
            m_f = m_rnd[10:0];
        end

        // Exact cancellation gives +0; a denormal result has a clear hidden bit.
        if (m_f == 11'd0)      w_res = (s_x == s_y) ? {s_x, 15'd0} : 16'h0000;
        else if (e_r >= 6'd31) w_res = {s_x, 15'h7C00};
        else                   w_res = {s_x, (m_f[10] ? e_r[4:0] : 5'd0), m_f[9:0]};

        w_nan = (a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0) ||
                (a[14:0] == 15'h7C00 && b[14:0] == 15'h7C00 && a[15] != b[15]);
        if (w_nan)                      w_res = 16'h7E00;
        else if (w_x[14:10] == 5'h1F)   w_res = {s_x, 15'h7C00};
    end

    // Latency pipeline for result and valid.
    always_ff @(posedge clk) begin
        r_res[0] <= w_res;
        r_vld[0] <= valid_in;
        for (int i = 1; i < LAT; i++) begin
            r_res[i] <= r_res[i-1];
            r_vld[i] <= r_vld[i-1];
        end
    end

    assign result    = r_res[LAT-1];
    assign valid_out = r_vld[LAT-1];

endmodule

// File: rtl/y_xd_acc.sv
// y_out = y_in + xD elementwise in FP16, consumer end of the xD start/done/acc_sig handshake.
// Ports: clk, rst (sync, active-high); y_in_flat/y_done and xD_flat/xD_done from producers;
// acc_sig releases both producers; y_out_flat/done to the next stage, done_ack from it.
module y_xd_acc
    import y_xd_acc_pkg::*;
#(
    parameter int unsigned B     = 1,
    parameter int unsigned H     = 4,
    parameter int unsigned P     = 4,
    parameter int unsigned DW    = FP16_W,
    parameter int unsigned A_LAT = ADD_LAT,
    parameter int unsigned PAR_H = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [B*H*P*DW-1:0] y_in_flat,
    input  logic              y_done,
    input  logic [B*H*P*DW-1:0] xD_flat,
    input  logic              xD_done,
    output logic              acc_sig,
    output logic [B*H*P*DW-1:0] y_out_flat,
    output logic              done,
    input  logic              done_ack
);

    localparam int unsigned NE = B * H * P;
    localparam int unsigned EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned HW = $clog2(H + 1);
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned FW = $clog2(A_LAT + 3);

    logic [1:0]    r_state, w_state_nxt;
    logic [BW-1:0] r_b, w_b_nxt;
    logic [HW-1:0] r_h, w_h_nxt;
    logic [PW-1:0] r_p, w_p_nxt;
    logic [FW-1:0] r_fcnt, w_fcnt_nxt;
    logic          r_acc_sig, w_acc_nxt, r_done, w_done_nxt, w_cap;

    logic [DW-1:0] r_y_buf [NE];
    logic [DW-1:0] r_x_buf [NE];
    logic [DW-1:0] r_y_out [NE];

    lane_tag_t     r_tag [PAR_H][A_LAT];
    lane_tag_t     w_lane_tag [PAR_H];
    int unsigned   w_lane_e [PAR_H];
    logic [DW-1:0] w_lane_a [PAR_H];
    logic [DW-1:0] w_lane_b [PAR_H];
    logic [DW-1:0] w_lane_res [PAR_H];
    logic [PAR_H-1:0] w_lane_vin, w_lane_vout;

    // Next state, counters and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_h_nxt     = r_h;
        w_p_nxt     = r_p;
        w_fcnt_nxt  = r_fcnt;
        w_acc_nxt   = 1'b0;
        w_done_nxt  = r_done;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (y_done && xD_done) begin
                    w_cap       = 1'b1;
                    w_acc_nxt   = 1'b1;
                    w_state_nxt = ST_CALC;
                    w_b_nxt     = '0;
                    w_h_nxt     = '0;
                    w_p_nxt     = '0;
                end
            end
            ST_CALC: begin
                if (r_p == PW'(P - 1)) begin
                    w_p_nxt = '0;
                    if (32'(r_h) + PAR_H >= H) begin
                        w_h_nxt = '0;
                        if (r_b == BW'(B - 1)) begin
                            w_b_nxt     = '0;
                            w_fcnt_nxt  = '0;
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_b_nxt = r_b + BW'(1);
                        end
                    end else begin
                        w_h_nxt = r_h + HW'(PAR_H);
                    end
                end else begin
                    w_p_nxt = r_p + PW'(1);
                end
            end
            ST_FLUSH: begin
                // Held until the last adder write has landed, with one spare cycle.
                if (r_fcnt == FW'(A_LAT + 1)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_fcnt_nxt = r_fcnt + FW'(1);
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane issue: lane i handles head h+i; lanes past H stay idle.
    always_comb begin
        for (int i = 0; i < PAR_H; i++) begin
            w_lane_e[i]         = 0;
            w_lane_vin[i]       = 1'b0;
            w_lane_a[i]         = '0;
            w_lane_b[i]         = '0;
            w_lane_tag[i]       = '0;
            if (r_state == ST_CALC && (32'(r_h) + 32'(i) < H)) begin
                w_lane_e[i]       = elem_idx(32'(r_b), 32'(r_h) + 32'(i), 32'(r_p), H, P);
                w_lane_vin[i]     = 1'b1;
                w_lane_a[i]       = r_y_buf[EW'(w_lane_e[i])];
                w_lane_b[i]       = r_x_buf[EW'(w_lane_e[i])];
                w_lane_tag[i].valid = 1'b1;
                w_lane_tag[i].idx   = TAG_IW'(w_lane_e[i]);
            end
        end
    end

    // State, counters and tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_b       <= '0;
            r_h       <= '0;
            r_p       <= '0;
            r_fcnt    <= '0;
            r_acc_sig <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < PAR_H; i++)
                for (int s = 0; s < A_LAT; s++)
                    r_tag[i][s] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_b       <= w_b_nxt;
            r_h       <= w_h_nxt;
            r_p       <= w_p_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_acc_sig <= w_acc_nxt;
            r_done    <= w_done_nxt;
            for (int i = 0; i < PAR_H; i++) begin
                r_tag[i][0] <= w_lane_tag[i];
                for (int s = 1; s < A_LAT; s++)
                    r_tag[i][s] <= r_tag[i][s-1];
            end
        end
    end

    // Operand snapshots, so producers may restart as soon as acc_sig fires.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int e = 0; e < NE; e++) begin
                r_y_buf[e] <= y_in_flat[e*DW +: DW];
                r_x_buf[e] <= xD_flat[e*DW +: DW];
            end
        end
    end

    // Result write-back; a valid tag is required, so stale adder outputs after reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NE; e++) r_y_out[e] <= '0;
        end else begin
            for (int i = 0; i < PAR_H; i++) begin
                if (w_lane_vout[i] && r_tag[i][A_LAT-1].valid && 32'(r_tag[i][A_LAT-1].idx) < NE)
                    r_y_out[EW'(r_tag[i][A_LAT-1].idx)] <= w_lane_res[i];
            end
        end
    end

    for (genvar g = 0; g < PAR_H; g++) begin : g_lane
        fp16_add_wrapper #(.LAT(A_LAT)) u_add (
            .clk       (clk),
            .a         (w_lane_a[g]),
            .b         (w_lane_b[g]),
            .valid_in  (w_lane_vin[g]),
            .result    (w_lane_res[g]),
            .valid_out (w_lane_vout[g])
        );
    end

    for (genvar g = 0; g < NE; g++) begin : g_out
        assign y_out_flat[g*DW +: DW] = r_y_out[g];
    end

    assign acc_sig = r_acc_sig;
    assign done    = r_done;

endmodule
